// File: rtl/parity_pkg.sv
// Shared types and constants for the sequenced parity indicator.
// Used by the scan controller and any lab top that drives the same RGB LED.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int RGB_ODD  = 0;
    localparam int RGB_EVEN = 1;
    localparam int RGB_BUSY = 2;

    // LED pattern for a given controller state and last parity result.
    function automatic logic [2:0] rgb_code(input scan_state_t st, input logic par);
        logic [2:0] code;
        code = '0;
        case (st)
            SHIFT: code[RGB_BUSY] = 1'b1;
            SHOW: begin
                code[RGB_ODD]  = par;
                code[RGB_EVEN] = ~par;
            end
            default: code = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: multi-stage synchronizer, consecutive-stable-cycle
// debounce and a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // cnt_q counts consecutive cycles the synchronized input disagrees with
    // the accepted level; any agreement restarts the qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_o <= 1'b0;
            rise_o  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            rise_o <= 1'b0;
            if (sync_bit == level_o) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_o <= sync_bit;
                rise_o  <= sync_bit;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/parity_scan_ctrl.sv
// Button-started bit-serial parity scan of the switch word, result shown on
// the RGB LED for a fixed time.
//
//   state | meaning
//   IDLE  | LED off, waiting for a debounced press
//   SHIFT | busy LED, one switch bit folded into the accumulator per cycle
//   SHOW  | odd/even LED lit; a new press restarts the scan immediately
module parity_scan_ctrl
    import parity_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int SHOW_CYC     = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn,
    output logic [2:0]        RGB0,
    output logic              parity_o,
    output logic              done_o
);

    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int SHOW_W = $clog2(SHOW_CYC + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYC - 1);

    scan_state_t       state, state_next;
    logic [DATA_W-1:0] shreg;
    logic              acc;
    logic [BIT_W-1:0]  bitcnt;
    logic [SHOW_W-1:0] showcnt;
    logic              btn_level;
    logic              btn_rise;
    logic              start;
    logic              load;
    logic              finish;

    btn_debounce #(
        .SYNC_STAGES  (2),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn),
        .level_o (btn_level),
        .rise_o  (btn_rise)
    );

    // rise_o is only ever high in the first cycle the new level reads 1.
    assign start = btn_rise & btn_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                if (bitcnt == BIT_LAST) begin
                    state_next = SHOW;
                    finish     = 1'b1;
                end
            end
            SHOW: begin
                if (start) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                end else if (showcnt == SHOW_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The last bit is folded in on the finishing edge, so the published parity
    // includes shreg[0] of the final SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            acc      <= 1'b0;
            bitcnt   <= '0;
            showcnt  <= '0;
            parity_o <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            done_o <= finish;
            if (load) begin
                shreg  <= sw;
                acc    <= 1'b0;
                bitcnt <= '0;
            end else if (state == SHIFT) begin
                acc    <= acc ^ shreg[0];
                shreg  <= shreg >> 1;
                bitcnt <= bitcnt + BIT_W'(1);
            end
            if (finish) begin
                parity_o <= acc ^ shreg[0];
                showcnt  <= '0;
            end else if (state == SHOW) begin
                showcnt <= showcnt + SHOW_W'(1);
            end
        end
    end

    assign RGB0 = rgb_code(state, parity_o);

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Directed bench for parity_scan_ctrl with a cycle-level timeline model of
// button qualification and scan/show windows, compared every cycle.
module tb_parity_scan_ctrl;

    localparam int DW    = 8;
    localparam int DEB   = 4;
    localparam int SHOWN = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn = 1'b0;
    logic [DW-1:0] sw = '0;
    wire  [2:0]    rgb;
    wire           par;
    wire           done;

    always #5 clk = ~clk;

    parity_scan_ctrl #(
        .DATA_W       (DW),
        .DEBOUNCE_CYC (DEB),
        .SHOW_CYC     (SHOWN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn      (btn),
        .RGB0     (rgb),
        .parity_o (par),
        .done_o   (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // Cycle c is the interval after the c-th rising edge. A scan started by a
    // press qualified in cycle t is busy in t+1..t+DW, shows in
    // t+DW+1..t+DW+SHOWN and reports done in t+DW+1.
    int            cyc = 0;
    int            t_start = -1000;
    logic [DW-1:0] m_word = '0;
    logic          m_par = 1'b0;
    logic          m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0, m_rise = 1'b0;
    int            m_run = 0;

    function automatic bit in_shift(input int c);
        return (c >= t_start + 1) && (c <= t_start + DW);
    endfunction

    function automatic bit in_show(input int c);
        return (c >= t_start + DW + 1) && (c <= t_start + DW + SHOWN);
    endfunction

    always @(negedge clk) begin
        logic [2:0] e_rgb;
        logic       e_done;
        cyc++;
        if (!rst_n) begin
            t_start = -1000;
            m_par   = 1'b0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_level = 1'b0;
            m_rise  = 1'b0;
            m_run   = 0;
        end else begin
            if (m_rise && !in_shift(cyc - 1)) begin
                t_start = cyc - 1;
                m_word  = sw;
            end
            if (cyc == t_start + DW + 1)
                m_par = ^m_word;
            m_rise = 1'b0;
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = m_s2;
                    m_rise  = m_s2;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
        e_rgb  = in_shift(cyc) ? 3'b100 :
                 in_show(cyc)  ? {1'b0, ~m_par, m_par} : 3'b000;
        e_done = (cyc == t_start + DW + 1);
        check("rgb_model", {29'd0, rgb}, {29'd0, e_rgb});
        check("parity_model", {31'd0, par}, {31'd0, m_par});
        check("done_model", {31'd0, done}, {31'd0, e_done});
    end

    // ---------------- done monitor ----------------
    int   done_cnt = 0;
    logic first_par = 1'b0;

    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (done_cnt == 0) first_par = par;
            done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rgb[2] !== 1'b1 && n < 60);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 60);
        #1;
    endtask

    initial begin
        int n;
        tick(3);
        check("reset_rgb", {29'd0, rgb}, 32'd0);
        check("reset_parity", {31'd0, par}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick(3);

        // A5: four ones -> even
        sw = 8'hA5; btn = 1'b1;
        wait_busy(n);
        check("a5_busy_latency", n, 7);
        check("a5_busy_rgb", {29'd0, rgb}, 32'd4);
        wait_done(n);
        check("a5_done_latency", n, 8);
        check("a5_parity", {31'd0, par}, 32'd0);
        check("a5_rgb", {29'd0, rgb}, 32'd2);
        btn = 1'b0;
        tick(9);
        check("a5_show_last", {29'd0, rgb}, 32'd2);
        tick(1);
        check("a5_idle", {29'd0, rgb}, 32'd0);
        tick(10);

        // 07: three ones -> odd
        sw = 8'h07; btn = 1'b1;
        wait_busy(n);
        wait_done(n);
        check("07_done_latency", n, 8);
        check("07_parity", {31'd0, par}, 32'd1);
        check("07_rgb", {29'd0, rgb}, 32'd1);
        btn = 1'b0;
        tick(20);

        // short glitches, then a long hold
        done_cnt = 0;
        btn = 1'b1; tick(1); btn = 1'b0; tick(4);
        btn = 1'b1; tick(2); btn = 1'b0; tick(4);
        btn = 1'b1; tick(3); btn = 1'b0; tick(6);
        check("glitch_idle", {29'd0, rgb}, 32'd0);
        check("glitch_no_scan", done_cnt, 0);
        btn = 1'b1;
        wait_busy(n);
        check("hold_latency", n, 7);
        tick(13);
        btn = 1'b0;
        tick(30);
        check("hold_single_scan", done_cnt, 1);

        // sw change mid-SHIFT, second press lands in SHIFT and is dropped
        done_cnt = 0;
        sw = 8'h01;
        btn = 1'b1; tick(4); btn = 1'b0; tick(4); btn = 1'b1; tick(1);
        sw = 8'h03;
        tick(30);
        check("shift_press_scans", done_cnt, 1);
        check("sw_change_parity", {31'd0, first_par}, 32'd1);
        btn = 1'b0;
        tick(20);

        // second press lands in first SHOW cycle and restarts with sw=FF
        done_cnt = 0;
        sw = 8'h01;
        btn = 1'b1; tick(4); btn = 1'b0; tick(4);
        sw = 8'hFF; tick(1);
        btn = 1'b1; tick(4); btn = 1'b0;
        tick(40);
        check("restart_scans", done_cnt, 2);
        check("restart_first_parity", {31'd0, first_par}, 32'd1);
        check("restart_final_parity", {31'd0, par}, 32'd0);
        tick(5);

        // reset mid-SHIFT after an odd result
        sw = 8'h07; btn = 1'b1;
        wait_done(n);
        check("pre_reset_parity", {31'd0, par}, 32'd1);
        btn = 1'b0;
        tick(20);
        sw = 8'h0F; btn = 1'b1;
        wait_busy(n);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("abort_rgb", {29'd0, rgb}, 32'd0);
        check("abort_parity", {31'd0, par}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        tick(2);
        btn = 1'b0;
        rst_n = 1'b1;
        done_cnt = 0;
        tick(30);
        check("post_reset_idle", {29'd0, rgb}, 32'd0);
        check("post_reset_no_scan", done_cnt, 0);
        sw = 8'h80; btn = 1'b1;
        wait_busy(n);
        check("post_reset_latency", n, 7);
        wait_done(n);
        check("post_reset_parity", {31'd0, par}, 32'd1);
        btn = 1'b0;
        tick(7);

        // every switch word
        for (int v = 0; v < 256; v++) begin
            sw = v[7:0]; btn = 1'b1;
            wait_done(n);
            check("sweep_parity", {31'd0, par}, $countones(v[7:0]) % 2);
            check("sweep_even_odd", {31'd0, rgb[1]}, {31'd0, ~rgb[0]});
            btn = 1'b0;
            tick(7);
        end
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_scan_ctrl.md
Name: parity_scan_ctrl

Overview:
Sequences an 8-bit switch word through a bit-serial parity engine and drives the RGB LED with the result. A debounced push-button starts a scan. The block captures `sw`, shifts it LSB-first through an XOR accumulator and shows odd/even on `RGB0` for a fixed display time. It sits directly between the board switches/button and the RGB LED. It is the sequenced replacement for the pure-combinational parity indicator.

Parameters:
DATA_W, 8, width of the data word scanned
DEBOUNCE_CYC, 1000000, consecutive stable cycles needed to accept a button level (10 ms at 100 MHz)
SHOW_CYC, 50000000, cycles the result stays lit before returning to idle (0.5 s at 100 MHz)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
sw  in  DATA_W  data word (board switches), asynchronous to clk
btn  in  1  start button, raw and bouncy, asynchronous
RGB0  out  3  [0]=odd parity, [1]=even parity, [2]=busy (scan in progress)
parity_o  out  1  last computed parity (1 = odd number of ones)
done_o  out  1  one-cycle pulse when a scan completes

Behaviour:
- Reset is asynchronous on `rst_n` low. All state clears: FSM=IDLE, RGB0=3'b000, parity_o=0, done_o=0, counters=0, debounced level=0.
- Button path:
  - `btn` passes through a 2-FF synchronizer.
  - The debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYC consecutive cycles.
  - `start` is a one-cycle pulse on the 0->1 edge of the debounced level.
- `sw` is sampled only at capture. It is not synchronized further, because switches are quasi-static.
- FSM states: IDLE, SHIFT, SHOW.
  - IDLE:
    - RGB0=000.
    - On `start`: shreg<=sw, acc<=0, bitcnt<=0, go to SHIFT.
  - SHIFT:
    - RGB0=3'b100.
    - Each cycle: acc<=acc^shreg[0], shreg<=shreg>>1, bitcnt<=bitcnt+1.
    - When bitcnt==DATA_W-1, go to SHOW. On that transition: parity_o<=final acc, done_o<=1 for one cycle, showcnt<=0.
  - SHOW:
    - RGB0={1'b0, ~parity_o, parity_o}.
    - showcnt increments each cycle. When showcnt==SHOW_CYC-1, go to IDLE.
- Latency: `start` high in cycle T means SHIFT occupies T+1..T+DATA_W. SHOW, parity_o valid and done_o high all begin in cycle T+DATA_W+1.
- bitcnt width is $clog2(DATA_W+1). showcnt width is $clog2(SHOW_CYC+1). Neither counter wraps, because each is reloaded on state entry.
- Boundary cases:
  - `start` during SHIFT is ignored (no queueing).
  - `start` during SHOW restarts immediately: sw is captured and the FSM re-enters SHIFT. done_o is not asserted again until the new scan completes.
  - `sw` changing during SHIFT has no effect on the result.
  - Holding `btn` produces exactly one `start`. Releasing and re-pressing is required for another.
  - Bounces shorter than DEBOUNCE_CYC produce no `start`.
  - `rst_n` low mid-SHIFT or mid-SHOW aborts the scan, with outputs at their reset values the same cycle. After release the block waits in IDLE, and the debounced level re-qualifies from 0.
- parity_o holds its value between scans. It is not cleared on returning to IDLE.

Decomposition:
- Shared package (`parity_pkg`):
  - FSM state enum: IDLE=2'd0, SHIFT=2'd1, SHOW=2'd2.
  - RGB bit-index constants: RGB_ODD=0, RGB_EVEN=1, RGB_BUSY=2.
- One sub-module: `btn_debounce` (params SYNC_STAGES=2, DEBOUNCE_CYC; ports clk, rst_n, btn_i, level_o, rise_o). It is reusable by other lab tops.
- FSM, shift register and counters stay in `parity_scan_ctrl`.

Test Plan:
(Bench overrides DEBOUNCE_CYC=4 and SHOW_CYC=10.)
- Reset, sw=8'hA5, clean press. Response: RGB0=3'b100 for 8 cycles, then done_o pulse, parity_o=0, RGB0=3'b010 for 10 cycles, then 3'b000.
- sw=8'h07, press. Response: parity_o=1, RGB0=3'b001. done_o pulses exactly DATA_W+1 cycles after `start`.
- btn glitch pulses of 1–3 cycles, then a 20-cycle hold. Response: exactly one `start` (after 2 sync + 4 stable cycles). Hold does not retrigger.
- sw=8'h01 captured, then sw changed to 8'h03 on SHIFT cycle 3. Response: parity_o=1. A second press during SHIFT is ignored. A press during SHOW with sw=8'hFF restarts: new done_o with parity_o=0.
- Scan sw=8'h07 to completion (parity_o=1), then start a new scan and pull rst_n low at SHIFT cycle 4. Response: RGB0=000, parity_o=0, done_o=0 the same cycle. After release, no scan starts until a new debounced press.
- Exhaustive: all 256 sw values with back-to-back presses. Check parity_o==^sw every time and RGB0[1]==~RGB0[0] in SHOW.
